// File: rtl/hsst_frame_pkg.sv
// Shared constants and FSM state type for the HSST TX framer.
// K-codes sit in byte 0; the upper three bytes are filler data.
package hsst_frame_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

    localparam logic [31:0] IDLE_WORD_DEF = {24'h5050_50, K28_5};
    localparam logic [31:0] SOF_WORD_DEF  = {24'h5555_55, K27_7};
    localparam logic [31:0] EOF_WORD_DEF  = {24'h5555_55, K29_7};

    localparam logic [3:0] K_BYTE0 = 4'b0001;
    localparam logic [3:0] K_NONE  = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM,
        ST_EOF
    } state_e;

endpackage

// File: rtl/hsst_frame_csum.sv
// Payload checksum: 32-bit wrap-around accumulator.
// Ports: clk, tb_rst (async, active-high), clr_i / en_i (sync), data_i, sum_o.
module hsst_frame_csum (
    input  logic        clk,
    input  logic        tb_rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [31:0] sum_o
);

    logic [31:0] sum_q;
    logic [31:0] sum_d;

    // Clear wins over enable; carries out of bit 31 are dropped.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/hsst_tx_framer.sv
// Packet framer: FIFO read side -> HSST TX lane (SOF, HDR, payload, CSUM, EOF).
// Ports: clk, tb_rst; fifo_rd_data/_empty/_water_level in, fifo_rd_en out;
// tx_data/tx_k registered lane outputs; frame_cnt; sticky underrun_err.
module hsst_tx_framer
    import hsst_frame_pkg::*;
#(
    parameter int          PKT_WORDS = 256,
    parameter int          WL_WIDTH  = 12,
    parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEF,
    parameter logic [31:0] SOF_WORD  = SOF_WORD_DEF,
    parameter logic [31:0] EOF_WORD  = EOF_WORD_DEF
) (
    input  logic                clk,
    input  logic                tb_rst,
    input  logic [31:0]         fifo_rd_data,
    input  logic                fifo_rd_empty,
    input  logic [WL_WIDTH-1:0] fifo_rd_water_level,
    output logic                fifo_rd_en,
    output logic [31:0]         tx_data,
    output logic [3:0]          tx_k,
    output logic [15:0]         frame_cnt,
    output logic                underrun_err
);

    localparam logic [10:0]         LAST_W = 11'(PKT_WORDS - 1);
    localparam logic [15:0]         PKT16  = 16'(PKT_WORDS);
    localparam logic [WL_WIDTH-1:0] PKT_WL = WL_WIDTH'(PKT_WORDS);

    state_e      state_q;
    state_e      state_d;
    logic [10:0] wcnt_q;
    logic [10:0] wcnt_d;
    logic [31:0] tx_data_q;
    logic [31:0] tx_data_d;
    logic [3:0]  tx_k_q;
    logic [3:0]  tx_k_d;
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;
    logic        underrun_q;
    logic        underrun_d;

    logic        rd_en;
    logic        csum_clr;
    logic        csum_en;
    logic [31:0] csum;
    logic        start;

    // Only launch once a whole packet is buffered, so PAYLOAD never waits.
    assign start = (fifo_rd_water_level >= PKT_WL) && !fifo_rd_empty;

    hsst_frame_csum u_csum (
        .clk    (clk),
        .tb_rst (tb_rst),
        .clr_i  (csum_clr),
        .en_i   (csum_en),
        .data_i (fifo_rd_data),
        .sum_o  (csum)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tx_data_d   = IDLE_WORD;
        tx_k_d      = K_BYTE0;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        csum_clr    = 1'b0;
        csum_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                tx_data_d = SOF_WORD;
                state_d   = ST_HDR;
            end
            ST_HDR: begin
                // Read for word 0 issued here; data lands in PAYLOAD.
                tx_data_d = {frame_cnt_q, PKT16};
                tx_k_d    = K_NONE;
                rd_en     = 1'b1;
                csum_clr  = 1'b1;
                wcnt_d    = '0;
                state_d   = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                tx_data_d = fifo_rd_data;
                tx_k_d    = K_NONE;
                csum_en   = 1'b1;
                // Reads run one word ahead, so the last word needs none.
                if (wcnt_q < LAST_W) begin
                    rd_en  = 1'b1;
                    wcnt_d = wcnt_q + 11'd1;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                tx_data_d = csum;
                tx_k_d    = K_NONE;
                state_d   = ST_EOF;
            end
            ST_EOF: begin
                tx_data_d   = EOF_WORD;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign underrun_d = underrun_q | (rd_en & fifo_rd_empty);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            tx_data_q   <= IDLE_WORD;
            tx_k_q      <= K_BYTE0;
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tx_data_q   <= tx_data_d;
            tx_k_q      <= tx_k_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    assign fifo_rd_en   = rd_en;
    assign tx_data      = tx_data_q;
    assign tx_k         = tx_k_q;
    assign frame_cnt    = frame_cnt_q;
    assign underrun_err = underrun_q;

endmodule

// File: tb/tb_hsst_tx_framer.sv
// Bench for hsst_tx_framer: scoreboarded packets on a PKT_WORDS=4 instance,
// plus a PKT_WORDS=2 instance for the checksum wrap case.
module tb_hsst_tx_framer;

    localparam logic [31:0] IDLE = 32'h5050_50BC;
    localparam logic [31:0] SOF  = 32'h5555_55FB;
    localparam logic [31:0] EOFW = 32'h5555_55FD;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    typedef struct {
        logic [3:0][31:0] w;
        logic [31:0]      cs;
    } vec_t;

    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A (PKT_WORDS = 4) ----------------
    logic [31:0] rd_data_a = '0;
    logic        empty_q_a = 1'b1;
    logic        force_empty = 1'b0;
    logic        empty_a;
    logic [11:0] wl_a = '0;
    logic        rd_en_a;
    logic [31:0] tx_data_a;
    logic [3:0]  tx_k_a;
    logic [15:0] fcnt_a;
    logic        uerr_a;
    logic [31:0] fa[$];
    logic [31:0] wq_a[$];

    assign empty_a = empty_q_a | force_empty;

    hsst_tx_framer #(.PKT_WORDS(4)) dut_a (
        .clk                 (clk),
        .tb_rst              (tb_rst),
        .fifo_rd_data        (rd_data_a),
        .fifo_rd_empty       (empty_a),
        .fifo_rd_water_level (wl_a),
        .fifo_rd_en          (rd_en_a),
        .tx_data             (tx_data_a),
        .tx_k                (tx_k_a),
        .frame_cnt           (fcnt_a),
        .underrun_err        (uerr_a)
    );

    // FIFO model: read data valid the cycle after rd_en; an empty read
    // leaves the previous data on the bus.
    always @(posedge clk) begin
        if (rd_en_a && !empty_a) rd_data_a <= fa.pop_front();
        while (wq_a.size() > 0) fa.push_back(wq_a.pop_front());
        wl_a      <= 12'(fa.size());
        empty_q_a <= (fa.size() == 0);
    end

    // ---------------- instance B (PKT_WORDS = 2) ----------------
    logic [31:0] rd_data_b = '0;
    logic        empty_b = 1'b1;
    logic [11:0] wl_b = '0;
    logic        rd_en_b;
    logic [31:0] tx_data_b;
    logic [3:0]  tx_k_b;
    logic [15:0] fcnt_b;
    logic        uerr_b;
    logic [31:0] fb[$];
    logic [31:0] wq_b[$];
    logic [35:0] qbo[$];

    hsst_tx_framer #(.PKT_WORDS(2)) dut_b (
        .clk                 (clk),
        .tb_rst              (tb_rst),
        .fifo_rd_data        (rd_data_b),
        .fifo_rd_empty       (empty_b),
        .fifo_rd_water_level (wl_b),
        .fifo_rd_en          (rd_en_b),
        .tx_data             (tx_data_b),
        .tx_k                (tx_k_b),
        .frame_cnt           (fcnt_b),
        .underrun_err        (uerr_b)
    );

    always @(posedge clk) begin
        if (rd_en_b && !empty_b) rd_data_b <= fb.pop_front();
        while (wq_b.size() > 0) fb.push_back(wq_b.pop_front());
        wl_b    <= 12'(fb.size());
        empty_b <= (fb.size() == 0);
    end

    always @(negedge clk) begin
        if (!tb_rst && !(tx_k_b == 4'b0001 && tx_data_b == IDLE)
            && qbo.size() < 8)
            qbo.push_back({tx_k_b, tx_data_b});
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    word_t sb[$];
    logic  mon_en = 1'b1;
    logic  chk_gap = 1'b0;
    int    gap = 0;
    logic  after_eof = 1'b0;
    int    rdcnt_a = 0;

    // Scoreboard monitor: every non-idle lane word pops one expectation.
    always @(negedge clk) begin
        word_t e;
        if (tb_rst) begin
            gap = 0;
            after_eof = 1'b0;
        end else begin
            if (rd_en_a) rdcnt_a++;
            if (tx_k_a == 4'b0001 && tx_data_a == IDLE) begin
                gap++;
            end else begin
                if (chk_gap && after_eof && tx_data_a == SOF)
                    chk("idle_gap", 64'(gap), 64'd1);
                gap = 0;
                after_eof = (tx_k_a == 4'b0001 && tx_data_a == EOFW);
                if (mon_en) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", {28'd0, tx_k_a, tx_data_a},
                            {28'd0, 4'b0001, IDLE});
                    end else begin
                        e = sb.pop_front();
                        chk("lane_word", {28'd0, tx_k_a, tx_data_a},
                            {28'd0, e.k, e.d});
                    end
                end
            end
        end
    end

    task automatic exp_word(input logic [31:0] d, input logic [3:0] k);
        word_t e;
        e.d = d;
        e.k = k;
        sb.push_back(e);
    endtask

    task automatic exp_pkt(input vec_t v, input logic [15:0] seq);
        exp_word(SOF, 4'b0001);
        exp_word({seq, 16'd4}, 4'b0000);
        for (int i = 0; i < 4; i++) exp_word(v.w[i], 4'b0000);
        exp_word(v.cs, 4'b0000);
        exp_word(EOFW, 4'b0001);
    endtask

    task automatic write_a(input vec_t v, input int n);
        for (int i = 0; i < n; i++) wq_a.push_back(v.w[i]);
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_word(input logic [31:0] d, input int lim,
                             output logic hit);
        int n = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            @(negedge clk);
            n++;
            hit = (tx_k_a == 4'b0001 && tx_data_a == d);
        end
    endtask

    task automatic pulse_reset();
        tb_rst = 1'b1;
        fa.delete();
        wq_a.delete();
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);
    endtask

    vec_t tbl[4];

    initial begin
        int   r0;
        logic hit;
        logic [35:0] expb[6];

        tbl[0].w = {32'h0008_0007, 32'h0006_0005, 32'h0004_0003, 32'h0002_0001};
        tbl[0].cs = 32'h0014_0010;
        tbl[1].w = {32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        tbl[1].cs = 32'h0000_0001;
        tbl[2].w = {32'h0000_0001, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        tbl[2].cs = 32'h1234_5679;
        tbl[3].w = {32'h0000_0000, 32'h5555_55FD, 32'h5555_55FB, 32'h5050_50BC};
        tbl[3].cs = 32'hFAFA_FCB4;

        expb[0] = {4'b0001, SOF};
        expb[1] = {4'b0000, 32'h0000_0002};
        expb[2] = {4'b0000, 32'hFFFF_FFFF};
        expb[3] = {4'b0000, 32'h0000_0002};
        expb[4] = {4'b0000, 32'h0000_0001};
        expb[5] = {4'b0001, EOFW};

        // Reset release with empty FIFOs.
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_tx_data", 64'(tx_data_a), 64'(IDLE));
        chk("rst_tx_k", 64'(tx_k_a), 64'h1);
        chk("rst_rd_en", 64'(rd_en_a), 64'h0);
        chk("rst_frame_cnt", 64'(fcnt_a), 64'h0);
        chk("rst_underrun", 64'(uerr_a), 64'h0);

        // PKT_WORDS=2 wrap-around checksum on instance B.
        wq_b.push_back(32'hFFFF_FFFF);
        wq_b.push_back(32'h0000_0002);

        // Three words buffered: must stay idle.
        r0 = rdcnt_a;
        exp_pkt(tbl[0], 16'd0);
        write_a(tbl[0], 3);
        repeat (10) @(negedge clk);
        chk("partial_rd_en", 64'(rdcnt_a - r0), 64'd0);
        chk("partial_idle", 64'(tx_data_a), 64'(IDLE));
        // Fourth word: water level hits 4 at the next edge, SOF two later.
        wq_a.push_back(tbl[0].w[3]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sof_early", 64'(tx_data_a), 64'(IDLE));
        @(posedge clk);
        @(negedge clk);
        chk("sof_latency", 64'(tx_data_a), 64'(SOF));
        wait_drain(40);
        chk("pkt0_frame_cnt", 64'(fcnt_a), 64'd1);
        chk("pkt0_rd_en_total", 64'(rdcnt_a - r0), 64'd4);

        for (int i = 1; i < 4; i++) begin
            r0 = rdcnt_a;
            exp_pkt(tbl[i], 16'(i));
            write_a(tbl[i], 4);
            wait_drain(40);
            chk("tbl_frame_cnt", 64'(fcnt_a), 64'(i + 1));
            chk("tbl_rd_en_total", 64'(rdcnt_a - r0), 64'd4);
        end

        for (int i = 0; i < 6; i++) begin
            if (i < qbo.size()) chk("pkt2_word", 64'(qbo[i]), 64'(expb[i]));
            else chk("pkt2_missing", 64'(qbo.size()), 64'd6);
        end

        // Reset in the middle of the payload.
        mon_en = 1'b0;
        write_a(tbl[2], 4);
        wait_word(SOF, 30, hit);
        chk("abort_sof_seen", 64'(hit), 64'd1);
        repeat (3) @(negedge clk);
        tb_rst = 1'b1;
        #1;
        chk("abort_tx_data", 64'(tx_data_a), 64'(IDLE));
        chk("abort_tx_k", 64'(tx_k_a), 64'h1);
        chk("abort_frame_cnt", 64'(fcnt_a), 64'h0);
        chk("abort_rd_en", 64'(rd_en_a), 64'h0);
        fa.delete();
        wq_a.delete();
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Twelve words at once: three packets, one idle apart.
        r0 = rdcnt_a;
        chk_gap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pkt(tbl[i], 16'(i));
            write_a(tbl[i], 4);
        end
        wait_drain(80);
        chk_gap = 1'b0;
        chk("b2b_frame_cnt", 64'(fcnt_a), 64'd3);
        chk("b2b_rd_en_total", 64'(rdcnt_a - r0), 64'd12);

        // Underrun: empty forced during the payload reads.
        mon_en = 1'b0;
        write_a(tbl[1], 4);
        wait_word(SOF, 30, hit);
        chk("urun_sof_seen", 64'(hit), 64'd1);
        force_empty = 1'b1;
        repeat (2) @(negedge clk);
        force_empty = 1'b0;
        chk("urun_set", 64'(uerr_a), 64'd1);
        wait_word(EOFW, 30, hit);
        chk("urun_eof_seen", 64'(hit), 64'd1);
        chk("urun_frame_cnt", 64'(fcnt_a), 64'd4);
        repeat (5) @(negedge clk);
        chk("urun_sticky", 64'(uerr_a), 64'd1);
        pulse_reset();
        chk("urun_cleared", 64'(uerr_a), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
